// File: rtl/fir_pkg.sv
// Shared definitions for the polyphase interpolating FIR: default widths,
// FSM state encoding and a reference coefficient table.
package fir_pkg;

    localparam int FIR_DATA_W_DEF = 16;
    localparam int FIR_COEF_W_DEF = 16;
    localparam int FIR_L_DEF      = 2;
    localparam int FIR_TPP_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Reference taps (index k*L+p), used to bring up the filter in test benches
    localparam logic signed [FIR_COEF_W_DEF-1:0] FIR_DEF_COEFS [4] = '{
        16'sd1024, 16'sd768, 16'sd512, 16'sd256
    };

endpackage

// File: rtl/fir_mac_unit.sv
// Single signed multiply-accumulate with synchronous clear and enable.
// acc_next_o exposes the sum including the current product so the caller can
// capture the final tap's result in the same cycle it is accumulated.
module fir_mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [COEF_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o,
    output logic signed [ACC_WIDTH-1:0]  acc_next_o
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_q;

    // Full-precision product, sign-extended into the accumulator width
    assign prod       = a_i * b_i;
    assign prod_ext   = ACC_WIDTH'(prod);
    assign acc_next_o = acc_q + prod_ext;
    assign acc_o      = acc_q;

    // Accumulator register: clear wins over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_next_o;
        end
    end

endmodule

// File: rtl/fir_interpolator.sv
// Polyphase upsample-by-L FIR. Every accepted input sample is shifted into a
// TPP-deep delay line, then L output phases are produced one after another,
// each computed by a single MAC stepping over that phase's TPP taps.
// Coefficients live in a register file writable only while idle.
module fir_interpolator
    import fir_pkg::*;
#(
    parameter int  DATA_WIDTH = FIR_DATA_W_DEF,
    parameter int  COEF_WIDTH = FIR_COEF_W_DEF,
    parameter int  L          = FIR_L_DEF,
    parameter int  TPP        = FIR_TPP_DEF,
    localparam int NTAPS      = L * TPP,
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TPP),
    localparam int AW         = $clog2(NTAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    input  logic                         out_ready,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wdata,
    output logic                         busy
);

    localparam int KW = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int PW = $clog2(L);

    fir_state_e state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [KW-1:0] k_q, k_d;
    logic          out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic          in_ready_q;

    logic signed [DATA_WIDTH-1:0] d_q    [TPP];
    logic signed [COEF_WIDTH-1:0] coef_q [NTAPS];

    logic          shift_en;
    logic          mac_clr;
    logic          mac_en;
    logic          last_tap;
    logic          coef_wr_en;
    logic [AW-1:0] tap_idx;
    logic signed [ACC_WIDTH-1:0] acc_cur;
    logic signed [ACC_WIDTH-1:0] acc_next;

    // Tap k of phase p sits at coefficient index k*L+p
    assign tap_idx  = AW'(int'(k_q) * L + int'(p_q));
    assign last_tap = (k_q == KW'(TPP - 1));

    // Writes land only while idle, so a sample in flight never sees a changing tap set
    assign coef_wr_en = coef_we && (state_q == IDLE) && (int'(coef_addr) < NTAPS);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);

    fir_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (mac_clr),
        .en_i       (mac_en),
        .a_i        (d_q[k_q]),
        .b_i        (coef_q[tap_idx]),
        .acc_o      (acc_cur),
        .acc_next_o (acc_next)
    );

    // Next-state and datapath control: accept, step taps, present, advance phase
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        shift_en    = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_en = 1'b1;
                    mac_clr  = 1'b1;
                    p_d      = '0;
                    k_d      = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_tap) begin
                    // Capture the sum including this cycle's product
                    out_data_d  = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (p_q == PW'(L - 1)) begin
                        state_d = IDLE;
                    end else begin
                        p_d     = p_q + PW'(1);
                        k_d     = '0;
                        mac_clr = 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; in_ready tracks the registered state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= (state_d == IDLE);
        end
    end

    // Delay line: newest sample enters at d[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '{default: '0};
        end else if (shift_en) begin
            d_q[0] <= in_data;
            for (int i = 1; i < TPP; i++) begin
                d_q[i] <= d_q[i-1];
            end
        end
    end

    // Coefficient register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q <= '{default: '0};
        end else if (coef_wr_en) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_interpolator.sv
// Directed bench for fir_interpolator with default parameters (L=2, TPP=2).
module tb_fir_interpolator;
    import fir_pkg::*;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int ACC_W = 33;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [DW-1:0]    in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ready;
    logic                    coef_we;
    logic [1:0]              coef_addr;
    logic signed [CW-1:0]    coef_wdata;
    logic                    busy;

    int ncomp = 0;
    int nfail = 0;

    fir_interpolator #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .L          (2),
        .TPP        (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [CW-1:0] w);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = w;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic load_default_coefs();
        for (int i = 0; i < 4; i++) write_coef(2'(i), FIR_DEF_COEFS[i]);
    endtask

    // Present one sample (optionally with a coefficient write in the same cycle)
    task automatic send(input logic signed [DW-1:0] x, input bit we,
                        input logic [1:0] a, input logic signed [CW-1:0] w);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        in_valid   = 1'b1;
        in_data    = x;
        coef_we    = we;
        coef_addr  = a;
        coef_wdata = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    // Wait (bounded) for out_valid, capture data, let one edge pass for the handshake
    task automatic collect(output logic signed [ACC_W-1:0] v, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid) begin
            v = out_data;
            @(posedge clk);
            #1;
        end else begin
            v = 'x;
            n = -1;
        end
    endtask

    task automatic test_reset();
        logic signed [ACC_W-1:0] v;
        int n;
        do_reset();
        ncomp++;
        if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, {ACC_W{1'b0}}}) begin
            nfail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b data=%0d, required rdy=1 vld=0 busy=0 data=0",
                     in_ready, out_valid, busy, out_data);
        end
        write_coef(2'd0, 16'sd1024);
        send(16'sd1, 1'b0, 2'd0, 16'sd0);
        ncomp++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL busy_in_mac: got %b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        ncomp++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL async_rst_out_valid: got %b, required 0", out_valid);
        end
        ncomp++;
        if (in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL async_rst_in_ready: got %b, required 1", in_ready);
        end
        ncomp++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL async_rst_busy: got %b, required 0", busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        // Coefficients were cleared by reset: impulse gives zeros
        send(16'sd1, 1'b0, 2'd0, 16'sd0);
        for (int ph = 0; ph < 2; ph++) begin
            collect(v, n);
            ncomp++;
            if (v !== 33'sd0) begin
                nfail++;
                $display("FAIL post_reset_impulse[%0d]: got %0d, required 0", ph, v);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] exp_v [6];
        logic signed [DW-1:0]    xin   [3];
        int n;
        exp_v = '{33'sd1024, 33'sd768, 33'sd512, 33'sd256, 33'sd0, 33'sd0};
        xin   = '{16'sd1, 16'sd0, 16'sd0};
        do_reset();
        load_default_coefs();
        for (int s = 0; s < 3; s++) begin
            send(xin[s], 1'b0, 2'd0, 16'sd0);
            for (int ph = 0; ph < 2; ph++) begin
                collect(v, n);
                ncomp++;
                if (v !== exp_v[s*2+ph]) begin
                    nfail++;
                    $display("FAIL impulse_out[%0d]: got %0d, required %0d", s*2+ph, v, exp_v[s*2+ph]);
                end
                if (s == 0) begin
                    ncomp++;
                    if (n !== 2) begin
                        nfail++;
                        $display("FAIL impulse_latency[%0d]: got %0d cycles, required 2", ph, n);
                    end
                end
            end
        end
    endtask

    task automatic test_extreme();
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] exp_v [4];
        int n;
        exp_v = '{33'sd1073741824, 33'sd1073741824, 33'sd2147483648, 33'sd2147483648};
        do_reset();
        for (int i = 0; i < 4; i++) write_coef(2'(i), 16'sh8000);
        for (int s = 0; s < 2; s++) begin
            send(16'sh8000, 1'b0, 2'd0, 16'sd0);
            for (int ph = 0; ph < 2; ph++) begin
                collect(v, n);
                ncomp++;
                if (v !== exp_v[s*2+ph]) begin
                    nfail++;
                    $display("FAIL extreme_out[%0d]: got %0d, required %0d", s*2+ph, v, exp_v[s*2+ph]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] exp_v [2];
        int t;
        exp_v = '{33'sd1024, 33'sd768};
        do_reset();
        load_default_coefs();
        out_ready = 1'b0;
        send(16'sd1, 1'b0, 2'd0, 16'sd0);
        for (int ph = 0; ph < 2; ph++) begin
            t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            v = out_valid ? out_data : 'x;
            ncomp++;
            if (v !== exp_v[ph]) begin
                nfail++;
                $display("FAIL bp_value[%0d]: got %0d, required %0d", ph, v, exp_v[ph]);
            end
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                ncomp++;
                if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_v[ph]}) begin
                    nfail++;
                    $display("FAIL bp_hold[%0d.%0d]: got vld=%b rdy=%b data=%0d, required vld=1 rdy=0 data=%0d",
                             ph, c, out_valid, in_ready, out_data, exp_v[ph]);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            ncomp++;
            if (out_valid !== 1'b0) begin
                nfail++;
                $display("FAIL bp_release[%0d]: got vld=%b, required 0", ph, out_valid);
            end
        end
        ncomp++;
        if (in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL bp_back_idle: got in_ready=%b, required 1", in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_coef_write_busy();
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] exp_v [4];
        int n;
        exp_v = '{33'sd1024, 33'sd768, 33'sd517, 33'sd1024};
        do_reset();
        load_default_coefs();
        send(16'sd1, 1'b0, 2'd0, 16'sd0);
        // Write attempt while the MAC is running must be dropped
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 16'sd5;
        @(posedge clk);
        #1 coef_we = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            collect(v, n);
            ncomp++;
            if (v !== exp_v[ph]) begin
                nfail++;
                $display("FAIL coef_busy_drop[%0d]: got %0d, required %0d", ph, v, exp_v[ph]);
            end
        end
        // Same write concurrent with acceptance: d=[1,1] -> 5+512, 768+256
        send(16'sd1, 1'b1, 2'd0, 16'sd5);
        for (int ph = 0; ph < 2; ph++) begin
            collect(v, n);
            ncomp++;
            if (v !== exp_v[2+ph]) begin
                nfail++;
                $display("FAIL coef_idle_concurrent[%0d]: got %0d, required %0d", ph, v, exp_v[2+ph]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [ACC_W-1:0] outs  [8];
        logic signed [ACC_W-1:0] exp_v [8];
        logic signed [DW-1:0]    xin   [4];
        int acc_cyc [4];
        int nacc;
        int nout;
        exp_v = '{33'sd1024, 33'sd768, 33'sd512, 33'sd256, 33'sd0, 33'sd0, 33'sd0, 33'sd0};
        xin   = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
        outs  = '{default: '0};
        acc_cyc = '{default: 0};
        do_reset();
        load_default_coefs();
        out_ready = 1'b1;
        nacc = 0;
        nout = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (out_valid) begin
                if (nout < 8) outs[nout] = out_data;
                nout++;
            end
            in_valid = (nacc < 4);
            if (in_valid && in_ready) begin
                in_data      = xin[nacc];
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ncomp++;
        if (nout !== 8) begin
            nfail++;
            $display("FAIL b2b_out_count: got %0d, required 8", nout);
        end
        for (int i = 0; i < 8; i++) begin
            ncomp++;
            if (outs[i] !== exp_v[i]) begin
                nfail++;
                $display("FAIL b2b_out[%0d]: got %0d, required %0d", i, outs[i], exp_v[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ncomp++;
            if (acc_cyc[i+1] - acc_cyc[i] !== 7) begin
                nfail++;
                $display("FAIL b2b_period[%0d]: got %0d cycles, required 7", i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        test_reset();
        test_impulse();
        test_extreme();
        test_backpressure();
        test_coef_write_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
